// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA engine scheduler: defaults, FSM encoding, pointer helper.
package rsa_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int TIMEOUT_DEF = 65535;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Round-robin successor of index idx in a ring of n requesters.
   function automatic int next_ptr(input int idx, input int n);
      if (idx + 1 >= n) begin
         return 0;
      end else begin
         return idx + 1;
      end
   endfunction

endpackage

// File: rtl/rsa_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] winner
);

   logic [PW:0] idx_s;
   logic        found_s;

   // Scan the ring starting at ptr and mark the first requester found.
   always_comb begin
      winner  = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = {1'b0, ptr} + (PW+1)'(k);
         if (idx_s >= (PW+1)'(NREQ)) begin
            idx_s = idx_s - (PW+1)'(NREQ);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req[idx_s[PW-1:0]]) begin
            winner[idx_s[PW-1:0]] = 1'b1;
            found_s               = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/rsa_scheduler.sv
// Shares one RSA engine among NREQ requesters: round-robin grant, launch,
// wait for completion (with timeout abort) and return the result.
module rsa_scheduler
   import rsa_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_text,
   input  logic [NREQ*WIDTH-1:0] req_key,
   input  logic [NREQ*WIDTH-1:0] req_mod,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_text,
   output logic                  rsp_error,
   output logic                  eng_go,
   output logic                  eng_divide,
   output logic [WIDTH-1:0]      eng_input_text,
   output logic [WIDTH-1:0]      eng_key,
   output logic [WIDTH-1:0]      eng_mod,
   input  logic [WIDTH-1:0]      eng_output_text,
   input  logic                  eng_done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t           state_r, state_nxt_s;
   logic [PW-1:0]    ptr_r;
   logic [NREQ-1:0]  owner_r;
   logic [CW-1:0]    cnt_r;
   logic [NREQ-1:0]  winner_s;
   logic [PW-1:0]    win_idx_s;
   logic [WIDTH-1:0] text_sel_s, key_sel_s, mod_sel_s;
   logic             load_s, launch_s, finish_s, timeout_s;

   logic [NREQ-1:0]  grant_r, rsp_valid_r;
   logic [WIDTH-1:0] rsp_text_r, eng_text_r, eng_key_r, eng_mod_r;
   logic             rsp_error_r, eng_go_r, eng_divide_r;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req    (req),
      .ptr    (ptr_r),
      .winner (winner_s)
   );

   // Encode the one-hot winner and select its operand slices.
   always_comb begin
      win_idx_s  = '0;
      text_sel_s = '0;
      key_sel_s  = '0;
      mod_sel_s  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner_s[i]) begin
            win_idx_s  = PW'(i);
            text_sel_s = req_text[i*WIDTH +: WIDTH];
            key_sel_s  = req_key[i*WIDTH +: WIDTH];
            mod_sel_s  = req_mod[i*WIDTH +: WIDTH];
         end else begin
            win_idx_s = win_idx_s;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and single-cycle control strobes for the datapath.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      launch_s    = 1'b0;
      finish_s    = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|req) begin
               load_s      = 1'b1;
               state_nxt_s = ST_LAUNCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            launch_s    = 1'b1;
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            // Completion wins over a timeout landing in the same cycle.
            if (eng_done) begin
               finish_s    = 1'b1;
               state_nxt_s = ST_RESP;
            end else if (cnt_r == CW'(TIMEOUT)) begin
               finish_s    = 1'b1;
               timeout_s   = 1'b1;
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Datapath: arbitration pointer, operand capture, engine handshake, response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r        <= '0;
         owner_r      <= '0;
         cnt_r        <= '0;
         grant_r      <= '0;
         rsp_valid_r  <= '0;
         rsp_text_r   <= '0;
         rsp_error_r  <= 1'b0;
         eng_go_r     <= 1'b0;
         eng_divide_r <= 1'b0;
         eng_text_r   <= '0;
         eng_key_r    <= '0;
         eng_mod_r    <= '0;
      end else begin
         grant_r      <= load_s ? winner_s : '0;
         eng_divide_r <= launch_s;
         rsp_valid_r  <= finish_s ? owner_r : '0;
         rsp_error_r  <= timeout_s;
         rsp_text_r   <= (finish_s && !timeout_s) ? eng_output_text : '0;
         if (load_s) begin
            owner_r    <= winner_s;
            ptr_r      <= PW'(next_ptr(int'(win_idx_s), NREQ));
            eng_text_r <= text_sel_s;
            eng_key_r  <= key_sel_s;
            eng_mod_r  <= mod_sel_s;
         end
         if (launch_s) begin
            eng_go_r <= 1'b1;
         end else if (finish_s) begin
            eng_go_r <= 1'b0;
         end
         if (launch_s) begin
            cnt_r <= '0;
         end else if (state_r == ST_WAIT && !finish_s) begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

   assign grant          = grant_r;
   assign rsp_valid      = rsp_valid_r;
   assign rsp_text       = rsp_text_r;
   assign rsp_error      = rsp_error_r;
   assign eng_go         = eng_go_r;
   assign eng_divide     = eng_divide_r;
   assign eng_input_text = eng_text_r;
   assign eng_key        = eng_key_r;
   assign eng_mod        = eng_mod_r;

endmodule

// File: tb/tb_rsa_scheduler.sv
// Scoreboard bench for rsa_scheduler with a behavioural engine (done 10 cycles after go rises).
module tb_rsa_scheduler;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 20;
   localparam int LAT_OK  = 12;
   localparam int LAT_TO  = 22;
   localparam int BOUND   = 300;

   logic                  clk   = 1'b0;
   logic                  reset = 1'b1;
   logic [NREQ-1:0]       req   = 4'b0000;
   logic [NREQ*WIDTH-1:0] req_text, req_key, req_mod;
   logic [NREQ-1:0]       grant, rsp_valid;
   logic [WIDTH-1:0]      rsp_text, eng_input_text, eng_key, eng_mod, eng_output_text;
   logic                  rsp_error, eng_go, eng_divide, eng_done;

   logic [WIDTH-1:0] text_v [NREQ];
   logic [WIDTH-1:0] key_v  [NREQ];
   logic [WIDTH-1:0] mod_v  [NREQ];

   typedef struct {
      int         idx;
      logic [31:0] text;
      logic       err;
      int         lat;
   } rsp_t;

   rsp_t rsp_q[$];
   int   grant_q[$];

   int   tests = 0, fails = 0, cyc = 0;
   int   grants_seen = 0, rsps_seen = 0, last_grant_cyc = 0, divides = 0;
   logic mute = 1'b0, spur_done = 1'b0, model_done = 1'b0, go_q = 1'b0;
   int   t = 0;

   rsa_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .req_text        (req_text),
      .req_key         (req_key),
      .req_mod         (req_mod),
      .grant           (grant),
      .rsp_valid       (rsp_valid),
      .rsp_text        (rsp_text),
      .rsp_error       (rsp_error),
      .eng_go          (eng_go),
      .eng_divide      (eng_divide),
      .eng_input_text  (eng_input_text),
      .eng_key         (eng_key),
      .eng_mod         (eng_mod),
      .eng_output_text (eng_output_text),
      .eng_done        (eng_done)
   );

   always #5 clk = ~clk;

   // Pack the per-requester operand tables onto the wide buses.
   always_comb begin
      req_text = '0;
      req_key  = '0;
      req_mod  = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_text[i*WIDTH +: WIDTH] = text_v[i];
         req_key[i*WIDTH +: WIDTH]  = key_v[i];
         req_mod[i*WIDTH +: WIDTH]  = mod_v[i];
      end
   end

   assign eng_output_text = eng_input_text + 32'd1;
   assign eng_done        = spur_done | model_done;

   // Cycle counter for latency measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: done is high in the 10th cycle after the first cycle of go.
   always @(negedge clk) begin
      if (!reset) begin
         t          = 0;
         model_done = 1'b0;
         go_q       = 1'b0;
      end else begin
         if (eng_go && !go_q) t = 0;
         else if (eng_go)     t = t + 1;
         model_done = eng_go && (t == 10) && !mute;
         go_q       = eng_go;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s", name);
   endtask

   // Monitor: pops expectations whenever the DUT presents a grant or a response.
   always @(negedge clk) begin
      if (reset) begin
         if (grant != 4'b0000) begin
            if (grant_q.size() == 0) begin
               fail_now("unexpected_grant");
            end else begin
               int e;
               logic [3:0] oh;
               e  = grant_q.pop_front();
               oh = 4'b0001 << e;
               check("grant", 64'(grant), 64'(oh));
               check("eng_text", 64'(eng_input_text), 64'(text_v[e]));
               check("eng_key", 64'(eng_key), 64'(key_v[e]));
               check("eng_mod", 64'(eng_mod), 64'(mod_v[e]));
            end
            grants_seen++;
            last_grant_cyc = cyc;
         end
         if (eng_divide) begin
            divides++;
            check("divide_timing", 64'(cyc - last_grant_cyc), 64'd1);
         end
         if (rsp_valid != 4'b0000) begin
            if (rsp_q.size() == 0) begin
               fail_now("unexpected_rsp");
            end else begin
               rsp_t r;
               logic [3:0] oh;
               r  = rsp_q.pop_front();
               oh = 4'b0001 << r.idx;
               check("rsp_valid", 64'(rsp_valid), 64'(oh));
               check("rsp_text", 64'(rsp_text), 64'(r.text));
               check("rsp_error", 64'(rsp_error), 64'(r.err));
               check("rsp_latency", 64'(cyc - last_grant_cyc), 64'(r.lat));
               check("go_low_in_resp", 64'(eng_go), 64'd0);
            end
            rsps_seen++;
         end
      end
   end

   task automatic expect_op(input int idx, input logic [31:0] text, input logic err, input int lat);
      rsp_t r;
      r.idx = idx; r.text = text; r.err = err; r.lat = lat;
      grant_q.push_back(idx);
      rsp_q.push_back(r);
   endtask

   task automatic wait_grants(input int target);
      int n = 0;
      while (grants_seen < target && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) fail_now("grant_wait_timeout");
   endtask

   task automatic wait_idle();
      int n = 0;
      while (rsp_q.size() != 0 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      if (n >= BOUND) fail_now("rsp_wait_timeout");
      repeat (3) @(negedge clk);
   endtask

   task automatic run_op(input logic [3:0] mask, input int n);
      int target;
      target = grants_seen + n;
      req = mask;
      wait_grants(target);
      req = 4'b0000;
      wait_idle();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, 64'(grant), 64'd0);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_rsp_text"}, 64'(rsp_text), 64'd0);
      check({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
      check({tag, "_eng_go"}, 64'(eng_go), 64'd0);
      check({tag, "_eng_divide"}, 64'(eng_divide), 64'd0);
      check({tag, "_eng_text"}, 64'(eng_input_text), 64'd0);
      check({tag, "_eng_key"}, 64'(eng_key), 64'd0);
      check({tag, "_eng_mod"}, 64'(eng_mod), 64'd0);
   endtask

   initial begin
      int d0, r0;
      for (int i = 0; i < NREQ; i++) begin
         text_v[i] = 32'h100 + 32'(i);
         key_v[i]  = 32'h1000 + 32'(i);
         mod_v[i]  = 32'hA000 + 32'(i);
      end
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Spurious done while idle must be ignored.
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("spur_grant", 64'(grant), 64'd0);
         check("spur_go", 64'(eng_go), 64'd0);
         check("spur_rsp", 64'(rsp_valid), 64'd0);
      end

      // Contention with all four held: 0,1,2,3,0.
      expect_op(0, 32'h101, 1'b0, LAT_OK);
      expect_op(1, 32'h102, 1'b0, LAT_OK);
      expect_op(2, 32'h103, 1'b0, LAT_OK);
      expect_op(3, 32'h104, 1'b0, LAT_OK);
      expect_op(0, 32'h101, 1'b0, LAT_OK);
      run_op(4'b1111, 5);

      // Single request with the reference operands.
      text_v[0] = 32'd5;
      key_v[0]  = 32'd65537;
      mod_v[0]  = 32'd36349;
      d0 = divides;
      expect_op(0, 32'd6, 1'b0, LAT_OK);
      run_op(4'b0001, 1);
      check("divide_pulses", 64'(divides - d0), 64'd1);

      // Move pointer to 3, then 1001 must go 3 then wrap to 0.
      expect_op(2, 32'h103, 1'b0, LAT_OK);
      run_op(4'b0100, 1);
      expect_op(3, 32'h104, 1'b0, LAT_OK);
      expect_op(0, 32'd6, 1'b0, LAT_OK);
      run_op(4'b1001, 2);

      // Timeout: engine silent.
      mute = 1'b1;
      text_v[1] = 32'hDEAD_BEEF;
      expect_op(1, 32'd0, 1'b1, LAT_TO);
      run_op(4'b0010, 1);
      check("go_after_timeout", 64'(eng_go), 64'd0);
      mute = 1'b0;

      // Reset in the middle of WAIT: no response, then normal service.
      r0 = rsps_seen;
      grant_q.push_back(3);
      req = 4'b1000;
      wait_grants(grants_seen + 1);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      check("no_rsp_after_reset", 64'(rsps_seen - r0), 64'd0);
      expect_op(2, 32'h103, 1'b0, LAT_OK);
      run_op(4'b0100, 1);

      check("grant_queue_drained", 64'(grant_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rsa_scheduler.md
RSA_SCHEDULER -- requirements
Module: rsa_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one rsa_rfid engine (2..8).
REQ-002 Parameter WIDTH, default 32, operand/result width, matches engine.
REQ-003 Parameter TIMEOUT, default 65535, max cycles waited for eng_done before abort.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester request level; held until grant.
REQ-007 req_text  input  NREQ*WIDTH  per-requester message, slice i = requester i.
REQ-008 req_key  input  NREQ*WIDTH  per-requester exponent.
REQ-009 req_mod  input  NREQ*WIDTH  per-requester modulus.
REQ-010 grant  output  NREQ  one-hot, one-cycle pulse: operands of that requester captured.
REQ-011 rsp_valid  output  NREQ  one-hot, one-cycle pulse: result for that requester on rsp_text.
REQ-012 rsp_text  output  WIDTH  result, valid only with rsp_valid.
REQ-013 rsp_error  output  1  qualifies rsp_valid: 1 = timeout, rsp_text = 0.
REQ-014 eng_go  output  1  engine go, held high launch..completion.
REQ-015 eng_divide  output  1  engine divide/load strobe, one-cycle pulse at launch.
REQ-016 eng_input_text, eng_key, eng_mod  output  WIDTH each  registered engine operands.
REQ-017 eng_output_text  input  WIDTH  engine result.
REQ-018 eng_done  input  1  engine completion, sampled only in WAIT.

Function
REQ-019 FSM states IDLE, LAUNCH, WAIT, RESP; one-hot or binary encoding free.
REQ-020 IDLE: if any req, pick winner by round-robin starting at ptr, pulse grant[winner], latch winner operands into eng_* registers, go LAUNCH (1 cycle).
REQ-021 Round-robin: after grant to i, ptr = (i+1) mod NREQ; wrap-around from NREQ-1 to 0.
REQ-022 LAUNCH: eng_go=1, eng_divide=1 for exactly this cycle, timeout counter cleared, go WAIT.
REQ-023 WAIT: eng_go=1; on eng_done=1 capture eng_output_text, go RESP; counter increments each cycle without done.
REQ-024 WAIT: counter reaching TIMEOUT -> rsp_error=1 registered, captured text forced 0, go RESP.
REQ-025 RESP: pulse rsp_valid[winner] one cycle with rsp_text/rsp_error, eng_go=0, go IDLE.
REQ-026 Latency: grant at cycle N, eng_go rises N+1, rsp_valid exactly 1 cycle after the cycle done is sampled high.
REQ-027 Minimum turnaround: next grant no earlier than the cycle after RESP (IDLE dwell one cycle).
REQ-028 req dropped before grant: ignored, no grant; req changes after grant do not affect in-flight operation.
REQ-029 Simultaneous requests: exactly one grant per operation; no requester starved beyond NREQ-1 operations.
REQ-030 eng_done asserted outside WAIT: ignored.
REQ-031 eng_* operand registers stable from LAUNCH through RESP.

Reset
REQ-032 reset low asynchronously forces: state IDLE, ptr 0, counter 0, grant 0, rsp_valid 0, rsp_text 0, rsp_error 0, eng_go 0, eng_divide 0, eng_* operands 0.
REQ-033 Reset mid-operation aborts without rsp_valid; in-flight request is lost, requester must re-request.
REQ-034 Release synchronous to clk by external synchronizer; first grant possible on first edge after release.

Structure
REQ-035 Shared package rsa_pkg holds WIDTH default, state encoding constants, TIMEOUT default.
REQ-036 One sub-module rr_arbiter (req, ptr -> one-hot winner, combinational), instantiated once.
REQ-037 Estimated 150-300 lines RTL; no memories, no multipliers.

Verification (engine behavioral model: done pulses 10 cycles after go rise, result = text+1 unless stated)
REQ-038 Single: req[0]=1, text=5, key=65537, mod=36349 -> grant[0] one cycle, eng_divide one pulse, rsp_valid[0] with rsp_text=6, rsp_error=0.
REQ-039 Contention: req=4'b1111 held -> grants in order 0,1,2,3,0; each rsp_valid matches its granted index.
REQ-040 Wrap: ptr=3 via prior grants, req=4'b1001 -> grant[3] then grant[0].
REQ-041 Timeout: TIMEOUT=20, model never asserts done -> rsp_valid[winner], rsp_error=1, rsp_text=0 at cycle 22 after launch; eng_go drops.
REQ-042 Reset mid-WAIT: reset low 3 cycles after launch -> all outputs 0 immediately, no rsp_valid; new req[2] after release served normally.
REQ-043 Spurious done: eng_done pulse in IDLE with no req -> no state change, no rsp_valid.
